dma_priority_arbiter: RTL

Request/priority front end of the DMA controller: samples the four channel request lines DREQ[3:0], applies the channel mask, raises HRQ to the bus owner, and on HLDA grants exactly one channel via DACK[3:0]. It sits directly upstream of the transfer timing/address engine, which consumes DACK/ACTIVE_CH and reports end of transfer on EOP_N. It is the block that drives the DACK lines the DMA bus interface exposes.

---
 rtl/dma_priority_arbiter_if.sv | 27 ++
 rtl/dma_priority_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter_if.sv
// Channel request / grant bundle between the DMA register file, bus owner and arbiter.
// Latency: none (wires only).
// Backpressure: HRQ/HLDA hold handshake; DACK is held until the grant terminates.
interface dma_priority_arbiter_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] dreq;
  logic [NUM_CH-1:0] mask;
  logic              rotate;
  logic              hlda;
  logic              eop_n;
  logic              hrq;
  logic [NUM_CH-1:0] dack;
  logic [1:0]        active_ch;

  // Environment side: drives requests and bus-owner responses.
  modport master (
    output dreq, mask, rotate, hlda, eop_n,
    input  hrq, dack, active_ch
  );

  // Arbiter side.
  modport slave (
    input  dreq, mask, rotate, hlda, eop_n,
    output hrq, dack, active_ch
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// DMA request/priority front end: registers DREQ, masks, raises HRQ, grants one channel on HLDA.
// Latency: DREQ->HRQ 2 cycles, HLDA->DACK 1 cycle, termination->DACK/HRQ low 1 cycle.
// Backpressure: grant held until EOP_N/request drop/mask/HLDA loss; build with DMA_ROTATE_PRIORITY_EN for rotating priority.
module dma_priority_arbiter (
  input logic                   clk,
  input logic                   reset_n,
  dma_priority_arbiter_if.slave bus
);
  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

  state_t            state;
  logic [1:0]        rst_sync;
  logic              rst_n;
  logic [NUM_CH-1:0] dreq_q;
  logic [NUM_CH-1:0] pending;
  logic              hrq;
  logic [NUM_CH-1:0] dack;
  logic [1:0]        active_ch;
  logic [1:0]        arb_ptr;
  logic [1:0]        win;
  logic              win_vld;
  logic [1:0]        cand;
  logic              grant_end;

  // Reset synchronizer: assert immediately, release two clock edges after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Single sampling stage for the level-sensitive channel requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dreq_q <= '0;
    else        dreq_q <= bus.dreq;
  end

  assign pending = dreq_q & ~bus.mask;

  // Active grant ends on end-of-process, the owner dropping its request, or being masked off.
  assign grant_end = !bus.eop_n || !dreq_q[active_ch] || bus.mask[active_ch];

`ifdef DMA_ROTATE_PRIORITY_EN
  logic [1:0] ptr;
  logic       grant_done;

  assign grant_done = (state == GRANT) && (!bus.hlda || grant_end);

  // Rotation pointer: the channel whose grant just ended drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ptr <= 2'd0;
    else if (!bus.rotate) ptr <= 2'd0;
    else if (grant_done)  ptr <= active_ch + 2'd1;
  end

  assign arb_ptr = bus.rotate ? ptr : 2'd0;
`else
  wire unused_rotate = bus.rotate;

  assign arb_ptr = 2'd0;
`endif

  // Winner search: first pending channel walking upward from the pointer with wrap-around.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    cand    = 2'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = arb_ptr + 2'(i);
      if (!win_vld && pending[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Hold-request / grant FSM with registered HRQ, DACK and ACTIVE_CH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hrq       <= 1'b0;
      dack      <= '0;
      active_ch <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            hrq   <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          // Stay here until the owner answers, even if the request vanished meanwhile.
          if (bus.hlda) begin
            if (win_vld) begin
              dack      <= NUM_CH'(1) << win;
              active_ch <= win;
              state     <= GRANT;
            end else begin
              hrq   <= 1'b0;
              state <= RELEASE;
            end
          end
        end
        GRANT: begin
          // Losing the bus beats a normal termination in the same cycle.
          if (!bus.hlda) begin
            dack      <= '0;
            active_ch <= 2'd0;
            hrq       <= 1'b0;
            state     <= IDLE;
          end else if (grant_end) begin
            dack      <= '0;
            active_ch <= 2'd0;
            hrq       <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          if (!bus.hlda) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hrq       = hrq;
  assign bus.dack      = dack;
  assign bus.active_ch = active_ch;
endmodule
